// File: rtl/psram_port_arbiter_if.sv
// Handshake and pin-status bundle between the PSRAM port arbiter and its two clients.
// Each 2-bit field carries one bit per PSRAM port (bit 0 = ram0, bit 1 = ram1); state packs two 2-bit port states.
interface psram_port_arbiter_if;
    logic [1:0] cpu_req;
    logic [1:0] cpu_gnt;
    logic [1:0] uspi_req;
    logic [1:0] uspi_cs;
    logic [1:0] cpu_cs;
    logic [1:0] sel;
    logic [1:0] preempt;
    logic [3:0] state;

    modport master (
        output cpu_req, uspi_req, uspi_cs, cpu_cs,
        input  cpu_gnt, sel, preempt, state
    );

    modport slave (
        input  cpu_req, uspi_req, uspi_cs, cpu_cs,
        output cpu_gnt, sel, preempt, state
    );
endinterface

// File: rtl/psram_port_arbiter.sv
// Per-port PSRAM ownership arbiter (USPI vs CPU); handover only after the owner's CS has idled IDLE_CYCLES+1 cycles.
// Latency: cpu_req rise to cpu_gnt is 1+IDLE_CYCLES+1 cycles when USPI is idle; all outputs registered.
// Backpressure: requests are levels held until granted; PSRAM_ARB_PREEMPT_EN adds a CPU hold timeout with a preempt pulse.
module psram_port_arbiter #(
    parameter int IDLE_CYCLES  = 4,
    parameter int CPU_MAX_HOLD = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    psram_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_USPI    = 2'b00,
        ST_TO_CPU  = 2'b01,
        ST_CPU     = 2'b10,
        ST_TO_USPI = 2'b11
    } arb_state_t;

    if (IDLE_CYCLES < 1 || IDLE_CYCLES > 15) begin : g_bad_idle
        $error("psram_port_arbiter: IDLE_CYCLES must be 1..15");
    end
    if (CPU_MAX_HOLD < 2 || CPU_MAX_HOLD > 65535) begin : g_bad_hold
        $error("psram_port_arbiter: CPU_MAX_HOLD must be 2..65535");
    end

    localparam logic [3:0] IDLE_LIM = 4'(IDLE_CYCLES);
`ifdef PSRAM_ARB_PREEMPT_EN
    // Compared before the increment so the pulse lands exactly CPU_MAX_HOLD requesting cycles in.
    localparam logic [15:0] HOLD_LIM = 16'(CPU_MAX_HOLD - 1);
`endif

    logic [1:0] sel_v;
    logic [1:0] gnt_v;
    logic [1:0] pre_v;
    logic [3:0] state_v;

    for (genvar p = 0; p < 2; p++) begin : g_port
        arb_state_t st;
        logic [3:0] idle_cnt;
        logic       sel_r;
        logic       gnt_r;
        logic       uspi_idle;
`ifdef PSRAM_ARB_PREEMPT_EN
        logic [15:0] hold_cnt;
        logic        pre_r;
`endif

        assign uspi_idle = bus.uspi_cs[p] & ~bus.uspi_req[p];

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                st       <= ST_USPI;
                idle_cnt <= '0;
                sel_r    <= 1'b0;
                gnt_r    <= 1'b0;
`ifdef PSRAM_ARB_PREEMPT_EN
                hold_cnt <= '0;
                pre_r    <= 1'b0;
`endif
            end else begin
`ifdef PSRAM_ARB_PREEMPT_EN
                pre_r    <= 1'b0;
                hold_cnt <= '0;
`endif
                case (st)
                    ST_USPI: begin
                        idle_cnt <= '0;
                        if (bus.cpu_req[p]) begin
                            st <= ST_TO_CPU;
                        end
                    end

                    ST_TO_CPU: begin
                        if (!bus.cpu_req[p]) begin
                            st       <= ST_USPI;
                            idle_cnt <= '0;
                        end else if (!uspi_idle) begin
                            idle_cnt <= '0;
                        end else if (idle_cnt == IDLE_LIM) begin
                            // USPI must still be idle on the handover cycle itself.
                            st       <= ST_CPU;
                            idle_cnt <= '0;
                            sel_r    <= 1'b1;
                            gnt_r    <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + 4'd1;
                        end
                    end

                    ST_CPU: begin
                        idle_cnt <= '0;
                        if (!bus.cpu_req[p]) begin
                            st    <= ST_TO_USPI;
                            gnt_r <= 1'b0;
                        end
`ifdef PSRAM_ARB_PREEMPT_EN
                        else if (bus.uspi_req[p]) begin
                            if (hold_cnt == HOLD_LIM) begin
                                st    <= ST_TO_USPI;
                                gnt_r <= 1'b0;
                                pre_r <= 1'b1;
                            end else begin
                                hold_cnt <= hold_cnt + 16'd1;
                            end
                        end
`endif
                    end

                    ST_TO_USPI: begin
                        // CPU pins stay selected until the ungranted CPU has released CS.
                        if (!bus.cpu_cs[p]) begin
                            idle_cnt <= '0;
                        end else if (idle_cnt == IDLE_LIM) begin
                            st       <= ST_USPI;
                            idle_cnt <= '0;
                            sel_r    <= 1'b0;
                        end else begin
                            idle_cnt <= idle_cnt + 4'd1;
                        end
                    end

                    default: begin
                        st       <= ST_USPI;
                        idle_cnt <= '0;
                        sel_r    <= 1'b0;
                        gnt_r    <= 1'b0;
                    end
                endcase
            end
        end

        assign sel_v[p]           = sel_r;
        assign gnt_v[p]           = gnt_r;
        assign state_v[2*p +: 2]  = st;
`ifdef PSRAM_ARB_PREEMPT_EN
        assign pre_v[p]           = pre_r;
`endif
    end

`ifndef PSRAM_ARB_PREEMPT_EN
    assign pre_v = 2'b00;
`endif

    assign bus.sel     = sel_v;
    assign bus.cpu_gnt = gnt_v;
    assign bus.preempt = pre_v;
    assign bus.state   = state_v;

endmodule

// File: tb/tb_psram_port_arbiter.sv
// Directed handover/latency scenarios followed by random traffic, all checked against a cycle model of the ownership rules.
module tb_psram_port_arbiter;
    localparam int IDLE = 4;
    localparam int HOLD = 8;
`ifdef PSRAM_ARB_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    psram_port_arbiter_if bus();

    psram_port_arbiter #(.IDLE_CYCLES(IDLE), .CPU_MAX_HOLD(HOLD)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference: per port, an ownership phase plus run lengths of qualifying cycles.
    logic [1:0] m_st [2];
    int         m_run [2];
    int         m_hold [2];
    logic [1:0] m_pre;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int p = 0; p < 2; p++) begin
            m_st[p]   = 2'b00;
            m_run[p]  = 0;
            m_hold[p] = 0;
        end
        m_pre = 2'b00;
    endfunction

    function automatic void model_edge();
        for (int p = 0; p < 2; p++) begin
            m_pre[p] = 1'b0;
            case (m_st[p])
                2'b00: if (bus.cpu_req[p]) begin m_st[p] = 2'b01; m_run[p] = 0; end
                2'b01: if (!bus.cpu_req[p]) m_st[p] = 2'b00;
                       else begin
                           m_run[p] = (bus.uspi_cs[p] && !bus.uspi_req[p]) ? m_run[p] + 1 : 0;
                           if (m_run[p] > IDLE) begin m_st[p] = 2'b10; m_hold[p] = 0; end
                       end
                2'b10: if (!bus.cpu_req[p]) begin m_st[p] = 2'b11; m_run[p] = 0; end
                       else if (PREEMPT) begin
                           m_hold[p] = bus.uspi_req[p] ? m_hold[p] + 1 : 0;
                           if (m_hold[p] >= HOLD) begin m_pre[p] = 1'b1; m_st[p] = 2'b11; m_run[p] = 0; end
                       end
                default: begin
                    m_run[p] = bus.cpu_cs[p] ? m_run[p] + 1 : 0;
                    if (m_run[p] > IDLE) m_st[p] = 2'b00;
                end
            endcase
        end
    endfunction

    function automatic logic [9:0] model_out();
        logic [1:0] s;
        logic [1:0] g;
        for (int p = 0; p < 2; p++) begin
            s[p] = (m_st[p] == 2'b10) || (m_st[p] == 2'b11);
            g[p] = (m_st[p] == 2'b10);
        end
        return {s, g, m_pre, m_st[1], m_st[0]};
    endfunction

    // One clock: model follows the edge, outputs are compared at the falling edge.
    task automatic tick();
        logic [1:0] sel_before;
        logic [1:0] ucs;
        logic [1:0] ccs;
        sel_before = bus.sel;
        @(posedge clk);
        ucs = bus.uspi_cs;
        ccs = bus.cpu_cs;
        if (!resetn) model_reset();
        else model_edge();
        @(negedge clk);
        chk("model", {6'd0, bus.sel, bus.cpu_gnt, bus.preempt, bus.state}, {6'd0, model_out()});
        for (int p = 0; p < 2; p++) begin
            if (resetn && bus.sel[p] !== sel_before[p])
                chk("sel_cs_idle", {15'd0, sel_before[p] ? ccs[p] : ucs[p]}, 16'd1);
        end
    endtask

    initial begin
        int n;
        logic saw_pre;

        bus.cpu_req  = 2'b00;
        bus.uspi_req = 2'b00;
        bus.uspi_cs  = 2'b11;
        bus.cpu_cs   = 2'b11;
        resetn       = 1'b0;
        model_reset();
        #1;
        chk("reset_out", {6'd0, bus.sel, bus.cpu_gnt, bus.preempt, bus.state}, 16'd0);
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // Grant latency with USPI idle.
        bus.cpu_req[0] = 1'b1;
        n = 0;
        while (!bus.cpu_gnt[0] && n < 20) begin tick(); n++; end
        chk("grant_latency", 16'(n), 16'(IDLE + 2));
        chk("grant_sel", {14'd0, bus.sel}, 16'h1);
        chk("grant_state", {12'd0, bus.state}, 16'h2);
        chk("port1_untouched", {14'd0, bus.cpu_gnt[1], bus.sel[1]}, 16'h0);

        // Release latency with CS already high.
        bus.cpu_req[0] = 1'b0;
        tick();
        chk("release_gnt_drop", {15'd0, bus.cpu_gnt[0]}, 16'd0);
        n = 1;
        while (bus.sel[0] && n < 20) begin tick(); n++; end
        chk("release_latency", 16'(n), 16'(IDLE + 2));

        // CS glitch at idle count 3 restarts the window.
        bus.cpu_req[0] = 1'b1;
        tick();
        repeat (3) tick();
        bus.uspi_cs[0] = 1'b0;
        tick();
        chk("glitch_no_gnt", {15'd0, bus.cpu_gnt[0]}, 16'd0);
        bus.uspi_cs[0] = 1'b1;
        n = 0;
        while (!bus.cpu_gnt[0] && n < 20) begin tick(); n++; end
        chk("glitch_latency", 16'(n), 16'(IDLE + 1));
        bus.cpu_req[0] = 1'b0;
        repeat (IDLE + 3) tick();

        // Port 1: CPU drops request mid-burst, sel held until CS idles.
        bus.cpu_req[1] = 1'b1;
        n = 0;
        while (!bus.cpu_gnt[1] && n < 20) begin tick(); n++; end
        chk("p1_grant_latency", 16'(n), 16'(IDLE + 2));
        bus.cpu_cs[1]  = 1'b0;
        bus.cpu_req[1] = 1'b0;
        tick();
        chk("p1_gnt_drop", {14'd0, bus.cpu_gnt[1], bus.sel[1]}, 16'h1);
        repeat (9) tick();
        chk("p1_sel_hold", {12'd0, bus.state[3:2], 1'b0, bus.sel[1]}, 16'hD);
        bus.cpu_cs[1] = 1'b1;
        n = 0;
        while (bus.sel[1] && n < 20) begin tick(); n++; end
        chk("p1_release_latency", 16'(n), 16'(IDLE + 1));

        // Hold timeout while USPI demands port 0.
        bus.cpu_req[0] = 1'b1;
        n = 0;
        while (!bus.cpu_gnt[0] && n < 20) begin tick(); n++; end
        bus.uspi_req[0] = 1'b1;
        if (PREEMPT) begin
            n = 0;
            do begin tick(); n++; end while (!bus.preempt[0] && n < 30);
            chk("preempt_latency", 16'(n), 16'(HOLD));
            chk("preempt_state", {12'd0, bus.state[1:0], 1'b0, bus.cpu_gnt[0]}, 16'hC);
            tick();
            chk("preempt_one_pulse", {14'd0, bus.preempt}, 16'd0);
            n = 1;
            while (bus.state[1:0] != 2'b00 && n < 20) begin tick(); n++; end
            chk("preempt_to_uspi", 16'(n), 16'(IDLE + 1));
        end else begin
            saw_pre = 1'b0;
            repeat (20) begin tick(); saw_pre = saw_pre | bus.preempt[0]; end
            chk("no_preempt", {15'd0, saw_pre}, 16'd0);
            chk("hold_kept", {12'd0, bus.state[1:0], 1'b0, bus.cpu_gnt[0]}, 16'h9);
        end
        bus.cpu_req[0]  = 1'b0;
        bus.uspi_req[0] = 1'b0;
        repeat (IDLE + 4) tick();

        // Asynchronous reset while the CPU owns port 0 mid-burst.
        bus.cpu_req[0] = 1'b1;
        n = 0;
        while (!bus.cpu_gnt[0] && n < 20) begin tick(); n++; end
        bus.cpu_cs[0] = 1'b0;
        tick();
        resetn = 1'b0;
        #1;
        chk("async_reset", {6'd0, bus.sel, bus.cpu_gnt, bus.preempt, bus.state}, 16'd0);
        model_reset();
        tick();
        resetn = 1'b1;
        n = 0;
        while (!bus.cpu_gnt[0] && n < 20) begin tick(); n++; end
        chk("post_reset_latency", 16'(n), 16'(IDLE + 2));
        bus.cpu_req[0] = 1'b0;
        bus.cpu_cs[0]  = 1'b1;
        repeat (IDLE + 3) tick();

        // Random traffic on both ports.
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(15) == 0) bus.cpu_req[p]  = ~bus.cpu_req[p];
                if ($urandom_range(11) == 0) bus.uspi_req[p] = ~bus.uspi_req[p];
                bus.uspi_cs[p] = ($urandom_range(5) != 0);
                bus.cpu_cs[p]  = ($urandom_range(5) != 0);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/psram_port_arbiter.md
# psram_port_arbiter

Per-port ownership arbiter for the two QSPI PSRAM ports (ram0, ram1), shared between the flash-emulation engine (USPI side) and the CPU-driven SPI controller on the iomem bus. Replaces the raw CPU-written select with a handshake: ownership of a port changes only after the current owner's chip select has been idle long enough, so no PSRAM transaction is ever cut mid-burst. Its `sel` outputs drive the existing top-level muxes for CS, CLK, DO and DO-enable.

## Interface
- `IDLE_CYCLES`, default 4: consecutive cycles the owner's CS must be high (and the owner not requesting) before handover; range 1..15.
- `CPU_MAX_HOLD`, default 1024: cycles the CPU may keep a port while USPI requests it; preemption only; range 2..65535.
- `clk`  in  1  system clock (16 MHz domain).
- `resetn`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  2  per-port CPU ownership request, level.
- `cpu_gnt`  out  2  per-port grant; CPU may start a transaction only while high.
- `uspi_req`  in  2  per-port USPI demand, level, synchronous to `clk`.
- `uspi_cs`  in  2  USPI-side chip select per port, active-low.
- `cpu_cs`  in  2  CPU-controller chip select per port, active-low.
- `sel`  out  2  per-port mux select: 0 = USPI drives the port, 1 = CPU drives the port.
- `preempt`  out  2  one-cycle pulse when a CPU grant is revoked by timeout.
- `state`  out  4  `{port1_state, port0_state}`, 2-bit encodings below, for iomem status readback.

## Operation
- Two identical, independent per-port FSMs. Encodings: USPI=00, TO_CPU=01, CPU=10, TO_USPI=11.
- USPI: `sel`=0, `cpu_gnt`=0. If `cpu_req` is high, go to TO_CPU.
- TO_CPU: `sel`=0. An idle counter counts cycles with `uspi_cs`=1 and `uspi_req`=0; any other cycle clears it to 0.
  - When the counter reaches `IDLE_CYCLES`, go to CPU.
  - If `cpu_req` drops first, return to USPI and clear the counter.
- CPU: `sel`=1, `cpu_gnt`=1.
  - If `cpu_req` drops, go to TO_USPI.
  - With preemption compiled in: a hold counter increments each cycle `uspi_req`=1 and clears when `uspi_req`=0. At `CPU_MAX_HOLD`, pulse `preempt`, drop `cpu_gnt`, go to TO_USPI.
- TO_USPI: `sel`=1 (CPU still drives the pins), `cpu_gnt`=0. The idle counter counts `cpu_cs`=1 cycles; at `IDLE_CYCLES`, go to USPI.
  - A CPU that has lost its grant must finish or abort its burst and raise CS.
- Simultaneous events on the same cycle:
  - In CPU state, a `cpu_req` fall and a timeout both lead to TO_USPI; `preempt` pulses only if `cpu_req` is still high.
  - In TO_USPI, a new `cpu_req` is ignored until the FSM is back in USPI.
- USPI always wins ties: from USPI, a pending `cpu_req` is served only after the USPI idle condition holds.
- Counters saturate. `IDLE_CYCLES` uses a 4-bit counter; `CPU_MAX_HOLD` uses a 16-bit counter.

## Timing
- Reset values: `sel`=00, `cpu_gnt`=00, `preempt`=00, `state`=0000; all counters 0. USPI owns both ports.
- Reset mid-operation: ownership returns to USPI immediately. The CPU controller is reset by the same `resetn`.
- All outputs are registered and change on the `clk` edge after the decision cycle.
- Minimum latency, `cpu_req` rise to `cpu_gnt` high, with USPI already idle: 1 cycle (USPI→TO_CPU) + `IDLE_CYCLES` cycles + 1 cycle (→CPU). That is 6 cycles at default.
- Minimum latency, `cpu_req` fall (CS already high) to `sel`=0: 1 + `IDLE_CYCLES` + 1 cycles.
- `sel` never changes while the relevant owner's CS is low.

## Configuration
- Macro: `PSRAM_ARB_PREEMPT_EN`.
- Defined: the hold counter, timeout and `preempt` pulse are implemented.
- Undefined: the CPU keeps a port until it drops `cpu_req`; `preempt` is tied to 00; the hold counter is not built.

## Test plan
- Reset, then hold `uspi_cs`=11 and `uspi_req`=00; raise `cpu_req[0]` → `cpu_gnt[0]` rises exactly 6 cycles later, `sel`=01, port 1 is untouched.
- In TO_CPU, pulse `uspi_cs[0]` low for 1 cycle at idle count 3 → counter restarts; the grant arrives 5 cycles after CS returns high.
- CPU owns port 1 and drops `cpu_req[1]` while `cpu_cs[1]`=0 for 10 more cycles → `cpu_gnt[1]`=0 next cycle; `sel[1]` stays 1 until 5 cycles after `cpu_cs[1]` rises.
- With `PSRAM_ARB_PREEMPT_EN` and `CPU_MAX_HOLD`=8: CPU owns port 0, `uspi_req[0]`=1 → `preempt[0]` pulses once after 8 cycles, `cpu_gnt[0]`=0, and `state[1:0]` goes 10→11→00.
- Same stimulus without the macro → no `preempt`, grant held indefinitely; `state[1:0]` stays 10.
- Assert `resetn`=0 while in CPU with `cpu_cs[0]` low → `sel`, `cpu_gnt` and `state` are 0 asynchronously; after release, no grant appears without a fresh idle window.
